ucie_ctl_sb_tx_arbiter: RTL

Transmit-side sideband scheduler that shares the single N-bit sideband config transmit bus between three message requesters: link-state req/resp, advertised-capability, and error/unsupported response. It arbitrates round-robin, latches the winning message, serializes it LSB-first in N-bit beats with a valid strobe, and enforces the partner's credit flow control. It is the TX counterpart of the sideband RX path and consumes the credit pulses that path's partner returns.

---
 rtl/ucie_ctl_sb_tx_arbiter_pkg.sv | 32 +++
 rtl/ucie_ctl_sb_tx_arbiter_if.sv | 37 +++
 rtl/ucie_ctl_sb_tx_arbiter_rr.sv | 45 ++++
 rtl/ucie_ctl_sb_tx_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ucie_ctl_sb_tx_arbiter_pkg.sv
// Shared definitions for the sideband TX arbiter: requester count and
// indices, message field widths, FSM state encoding and a beat-count helper.
package ucie_ctl_sb_tx_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned MSG_HDR_W  = 32;
  localparam int unsigned MSG_DATA_W = 32;
  localparam int unsigned MSG_W      = MSG_HDR_W + MSG_DATA_W;

  // Requester indices into the request vector
  localparam int unsigned REQ_LSM    = 0;
  localparam int unsigned REQ_ADVCAP = 1;
  localparam int unsigned REQ_ERR    = 2;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Header sits in the low half so it goes out first when serialized LSB-first
  typedef struct packed {
    logic [MSG_DATA_W-1:0] data;
    logic [MSG_HDR_W-1:0]  hdr;
  } msg_t;

  // Number of bus beats needed for a message on an n-bit bus
  function automatic int unsigned msg_beats(input logic has_data, input int unsigned n);
    return has_data ? (MSG_W / n) : (MSG_HDR_W / n);
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_arbiter_if.sv
// Sideband TX arbiter bundle.
//   i_req / i_req_hdr / i_req_data / i_req_has_data : per-requester message offers
//   i_pl_cfg_crd   : credit return pulse from the link partner
//   o_ack          : one-cycle pulse to the granted requester on its last beat
//   o_lp_cfg(_vld) : serialized message beat and its strobe
//   o_busy         : message in flight
//   o_crd_count    : current transmit credit count
// The master modport is the requester/partner side, the slave modport the arbiter.
interface ucie_ctl_sb_tx_arbiter_if
  import ucie_ctl_sb_tx_arbiter_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CRD_W = 3
);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*MSG_HDR_W-1:0]  i_req_hdr;
  logic [NUM_REQ*MSG_DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_has_data;
  logic                          i_pl_cfg_crd;
  logic [NUM_REQ-1:0]            o_ack;
  logic [N-1:0]                  o_lp_cfg;
  logic                          o_lp_cfg_vld;
  logic                          o_busy;
  logic [CRD_W-1:0]              o_crd_count;

  modport master (
    output i_req, i_req_hdr, i_req_data, i_req_has_data, i_pl_cfg_crd,
    input  o_ack, o_lp_cfg, o_lp_cfg_vld, o_busy, o_crd_count
  );

  modport slave (
    input  i_req, i_req_hdr, i_req_data, i_req_has_data, i_pl_cfg_crd,
    output o_ack, o_lp_cfg, o_lp_cfg_vld, o_busy, o_crd_count
  );

endinterface

// File: rtl/ucie_ctl_sb_tx_arbiter_rr.sv
// Three-way round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector
//   en_i          : load the winner into the last-grant pointer
//   gnt_o         : one-hot grant (zero when nothing requests)
//   ptr_o         : index of the winner, i.e. the pointer value after a load
// Search starts one past the last grant; reset pointer makes requester 0 first.
module ucie_ctl_sb_tx_arbiter_rr
  import ucie_ctl_sb_tx_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         ptr_o
);

  logic [1:0] ptr_q;
  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest requester overwrites the rest
  always_comb begin
    gnt_o = '0;
    ptr_o = ptr_q;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = 2'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        ptr_o      = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 2'(REQ_ERR);
    end else if (en_i && (|req_i)) begin
      ptr_q <= ptr_o;
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX scheduler. Arbitrates round-robin between the link-state,
// advertised-capability and error requesters, latches the winning message and
// serializes it LSB-first in N-bit beats, gated by partner credits.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   sb (slave)   : requests, payloads, credit return in; beats, ack, status out
module ucie_ctl_sb_tx_arbiter
  import ucie_ctl_sb_tx_arbiter_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned CRD_MAX = 4,
  parameter int unsigned CRD_W   = 3
) (
  input logic                    i_clk,
  input logic                    i_rst,
  ucie_ctl_sb_tx_arbiter_if.slave sb
);

  localparam int unsigned BEAT_W = 7;

  if ((MSG_HDR_W % N) != 0) begin : g_bad_width
    $error("N must divide 32");
  end
  if (CRD_MAX >= (1 << CRD_W)) begin : g_bad_crd
    $error("CRD_W too narrow for CRD_MAX");
  end

  logic [0:0]         state_q;
  logic [MSG_W-1:0]   sh_q;
  logic               has_data_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  last_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [CRD_W-1:0]   crd_q;
  logic [CRD_W-1:0]   crd_d;

  logic               grant;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [1:0]         gnt_idx;
  msg_t               win_msg;
  logic               win_has_data;
  logic [BEAT_W-1:0]  win_last;

  assign grant = (state_q == ST_IDLE) && (|sb.i_req) && (crd_q != '0);

  ucie_ctl_sb_tx_arbiter_rr u_rr (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .req_i  (sb.i_req),
    .en_i   (grant),
    .gnt_o  (gnt_oh),
    .ptr_o  (gnt_idx)
  );

  always_comb begin
    win_msg.hdr  = sb.i_req_hdr[gnt_idx*MSG_HDR_W +: MSG_HDR_W];
    win_msg.data = sb.i_req_data[gnt_idx*MSG_DATA_W +: MSG_DATA_W];
    win_has_data = sb.i_req_has_data[gnt_idx];
    win_last     = BEAT_W'(msg_beats(win_has_data, N) - 1);
    last_q       = BEAT_W'(msg_beats(has_data_q, N) - 1);
  end

  // Grant and credit return in the same cycle cancel; returns saturate at CRD_MAX
  always_comb begin
    crd_d = crd_q;
    case ({grant, sb.i_pl_cfg_crd})
      2'b10:   crd_d = crd_q - CRD_W'(1);
      2'b01:   if (crd_q != CRD_W'(CRD_MAX)) crd_d = crd_q + CRD_W'(1);
      default: crd_d = crd_q;
    endcase
  end

  // The shift register low bits are the current beat; ack is registered one
  // beat ahead so it lines up with the last beat on the bus.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      has_data_q <= 1'b0;
      beat_q     <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      crd_q      <= CRD_W'(CRD_MAX);
    end else begin
      crd_q <= crd_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q    <= ST_SEND;
            sh_q       <= win_msg;
            has_data_q <= win_has_data;
            beat_q     <= '0;
            gnt_q      <= gnt_oh;
            ack_q      <= (win_last == '0) ? gnt_oh : '0;
          end
        end
        ST_SEND: begin
          if (beat_q == last_q) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
            sh_q   <= sh_q >> N;
            ack_q  <= ((beat_q + BEAT_W'(1)) == last_q) ? gnt_q : '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sb.o_lp_cfg     = sh_q[N-1:0];
  assign sb.o_lp_cfg_vld = (state_q == ST_SEND);
  assign sb.o_busy       = (state_q == ST_SEND);
  assign sb.o_ack        = ack_q;
  assign sb.o_crd_count  = crd_q;

endmodule
